// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for controllers sequencing the row/column-memory + MAC datapath.
// Holds the state encoding and the memory read latency seen by the MAC.
package matmul_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CLEAR = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ACC   = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        CLEAR = ST_CLEAR,
        RUN   = ST_RUN,
        ACC   = ST_ACC,
        OUT   = ST_OUT,
        DONE  = ST_DONE
    } state_e;

    // Port-B read data appears this many cycles after enb.
    localparam int MAC_RD_LAT = 1;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Command and vector-load stream between the layer controller (master) and the sequencer (slave).
// Starts are single-cycle pulses; the load stream is a plain valid/ready handshake.
interface matmul_sequencer_if #(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4
) ();
    logic                  start_load;
    logic                  start_calc;
    logic [In_D_Add_W-1:0] cfg_len;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [In_W-1:0]       ld_row;
    logic [In_W-1:0]       ld_col;
    logic                  busy;
    logic                  load_done;
    logic                  done;

    modport master (
        output start_load, start_calc, cfg_len, ld_valid, ld_row, ld_col,
        input  ld_ready, busy, load_done, done
    );

    modport slave (
        input  start_load, start_calc, cfg_len, ld_valid, ld_row, ld_col,
        output ld_ready, busy, load_done, done
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Purpose: loads row/col vectors into the dual-port memories and sequences one MAC dot product per command.
// Latency: load finishes on the N-th accepted beat; calc asserts done N+4 cycles after the accepted start.
// Backpressure: ld_ready is a pure state decode (high throughout LOAD); ld_valid gaps stall without writes.
module matmul_sequencer
    import matmul_ctrl_pkg::*;
#(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_sequencer_if.slave     cmd,
    output logic                  ena_r,
    output logic                  ena_c,
    output logic                  wea_r,
    output logic                  wea_c,
    output logic [In_D_Add_W-1:0] addra_r,
    output logic [In_D_Add_W-1:0] addra_c,
    output logic [In_W-1:0]       din_r,
    output logic [In_W-1:0]       din_c,
    output logic                  enb_r,
    output logic                  enb_c,
    output logic [In_D_Add_W-1:0] addrb_r,
    output logic [In_D_Add_W-1:0] addrb_c,
    output logic                  clr,
    output logic                  en_MAC,
    output logic                  en_MAC_out
);

    localparam logic [In_D_Add_W-1:0] ADDR_ONE = In_D_Add_W'(1);

    state_e                  state;
    state_e                  state_nxt;
    logic [In_D_Add_W-1:0]   len_q;
    logic [In_D_Add_W-1:0]   len_m1;
    logic [In_D_Add_W-1:0]   idx;
    logic [In_D_Add_W-1:0]   k;
    logic [MAC_RD_LAT-1:0]   enb_dly;
    logic                    wr;
    logic                    rd;
    logic                    last_beat;
    logic                    last_rd;

    assign len_m1    = len_q - ADDR_ONE;
    assign wr        = (state == LOAD) && cmd.ld_valid;
    assign rd        = (state == RUN);
    assign last_beat = wr && (idx == len_m1);
    assign last_rd   = rd && (k == len_m1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            len_q   <= '0;
            idx     <= '0;
            k       <= '0;
            enb_dly <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (state_nxt != IDLE)) begin
                len_q <= cmd.cfg_len;
            end
            if (wr) begin
                idx <= last_beat ? '0 : idx + ADDR_ONE;
            end
            if (rd) begin
                k <= last_rd ? '0 : k + ADDR_ONE;
            end
            // Delay line matching the memory read latency so en_MAC lines up with doutb.
            enb_dly <= MAC_RD_LAT'({enb_dly, rd});
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd.start_load && (cmd.cfg_len != '0)) begin
                    state_nxt = LOAD;
                end else if (cmd.start_calc && (cmd.cfg_len != '0)) begin
                    state_nxt = CLEAR;
                end
            end
            LOAD:    if (last_beat) state_nxt = IDLE;
            CLEAR:   state_nxt = RUN;
            RUN:     if (last_rd) state_nxt = ACC;
            ACC:     state_nxt = OUT;
            OUT:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd.ld_ready  = (state == LOAD);
    assign cmd.busy      = (state != IDLE);
    assign cmd.load_done = last_beat;
    assign cmd.done      = (state == DONE);

    assign ena_r   = wr;
    assign ena_c   = wr;
    assign wea_r   = wr;
    assign wea_c   = wr;
    assign addra_r = wr ? idx : '0;
    assign addra_c = wr ? idx : '0;
    assign din_r   = wr ? cmd.ld_row : '0;
    assign din_c   = wr ? cmd.ld_col : '0;

    assign enb_r   = rd;
    assign enb_c   = rd;
    assign addrb_r = rd ? k : '0;
    assign addrb_c = rd ? k : '0;

    assign clr        = (state == CLEAR);
    assign en_MAC     = enb_dly[MAC_RD_LAT-1];
    assign en_MAC_out = (state == OUT);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: memory/MAC stand-in, table of directed vectors plus random loads/calcs.
module tb_matmul_sequencer;

    localparam int W  = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.In_W(W), .In_D_Add_W(AW)) cmd ();

    logic          ena_r, ena_c, wea_r, wea_c, enb_r, enb_c, clr, en_MAC, en_MAC_out;
    logic [AW-1:0] addra_r, addra_c, addrb_r, addrb_c;
    logic [W-1:0]  din_r, din_c;

    matmul_sequencer #(.In_W(W), .In_D_Add_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .ena_r      (ena_r),
        .ena_c      (ena_c),
        .wea_r      (wea_r),
        .wea_c      (wea_c),
        .addra_r    (addra_r),
        .addra_c    (addra_c),
        .din_r      (din_r),
        .din_c      (din_c),
        .enb_r      (enb_r),
        .enb_c      (enb_c),
        .addrb_r    (addrb_r),
        .addrb_c    (addrb_c),
        .clr        (clr),
        .en_MAC     (en_MAC),
        .en_MAC_out (en_MAC_out)
    );

    // Stand-in for matrix_multiplier: two memories with 1-cycle read, MAC, output latch.
    logic [W-1:0] mem_r [16];
    logic [W-1:0] mem_c [16];
    logic [W-1:0] dout_r, dout_c, acc, y_q;

    always @(posedge clk) begin
        if (ena_r && wea_r) mem_r[addra_r] <= din_r;
        if (ena_c && wea_c) mem_c[addra_c] <= din_c;
        if (enb_r) dout_r <= mem_r[addrb_r];
        if (enb_c) dout_c <= mem_c[addrb_c];
        if (clr) acc <= '0;
        else if (en_MAC) acc <= acc + dout_r * dout_c;
        if (en_MAC_out) y_q <= acc;
    end

    logic [12:0] ctl_act;
    logic [79:0] bus_act;
    assign ctl_act = {cmd.busy, cmd.ld_ready, cmd.load_done, cmd.done, ena_r, ena_c, wea_r, wea_c,
                      enb_r, enb_c, clr, en_MAC, en_MAC_out};
    assign bus_act = {addra_r, addra_c, addrb_r, addrb_c, din_r, din_c};

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] ctl_exp(input bit busy, input bit ldr, input bit ldone, input bit dn,
                                            input bit wr, input bit enb, input bit cl, input bit mac,
                                            input bit mout);
        return {busy, ldr, ldone, dn, wr, wr, wr, wr, enb, enb, cl, mac, mout};
    endfunction

    // Reference: vectors currently held in the memories and the dot product they imply.
    logic [W-1:0] cur_row [15];
    logic [W-1:0] cur_col [15];
    logic [W-1:0] ref_row [15];
    logic [W-1:0] ref_col [15];

    function automatic logic [W-1:0] dot(input int n);
        logic [W-1:0] s = '0;
        for (int i = 0; i < n; i++) s = s + ref_row[i] * ref_col[i];
        return s;
    endfunction

    typedef struct {
        int                   n;
        int                   gap;   // 0: none, 1: alternate, 2: random
        bit                   both;
        bit                   stray;
        logic [14:0][W-1:0]   row;
        logic [14:0][W-1:0]   col;
        logic [W-1:0]         exp_y;
    } vec_t;

    vec_t tbl [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int n, input int gap, input bit both);
        int   beat;
        int   c;
        bit   v;
        logic [79:0] eb;
        cmd.start_load = 1'b1;
        cmd.start_calc = both;
        cmd.cfg_len    = AW'(n);
        @(negedge clk);
        chk("load_c0_idle", ctl_act, '0);
        step();
        cmd.start_load = 1'b0;
        cmd.start_calc = 1'b0;
        cmd.cfg_len    = AW'($urandom);
        beat = 0;
        c    = 1;
        while (beat < n && c <= 4 * n + 8) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (c % 2 == 1);
            else               v = ($urandom_range(0, 2) != 0);
            cmd.ld_valid = v;
            cmd.ld_row   = v ? cur_row[beat] : W'($urandom);
            cmd.ld_col   = v ? cur_col[beat] : W'($urandom);
            @(negedge clk);
            chk($sformatf("load_ctl n=%0d c=%0d", n, c), ctl_act,
                ctl_exp(1, 1, v && (beat == n - 1), 0, v, 0, 0, 0, 0));
            eb = v ? {AW'(beat), AW'(beat), AW'(0), AW'(0), cur_row[beat], cur_col[beat]} : '0;
            chk($sformatf("load_bus n=%0d c=%0d", n, c), bus_act, eb);
            step();
            if (v) beat++;
            c++;
        end
        cmd.ld_valid = 1'b0;
        chk("load_beats_within_budget", beat, n);
        for (int i = 0; i < n; i++) begin
            ref_row[i] = cur_row[i];
            ref_col[i] = cur_col[i];
        end
        @(negedge clk);
        chk("load_after_idle", ctl_act, '0);
        step();
    endtask

    task automatic run_calc(input int n, input bit stray, input logic [W-1:0] exp_y);
        int          mac_cnt = 0;
        int          max_b   = 0;
        bit          enb;
        bit          mac;
        logic [AW-1:0] ab;
        cmd.start_calc = 1'b1;
        cmd.cfg_len    = AW'(n);
        @(negedge clk);
        chk("calc_c0_idle", ctl_act, '0);
        step();
        cmd.start_calc = 1'b0;
        cmd.cfg_len    = AW'($urandom);
        for (int c = 1; c <= n + 4; c++) begin
            cmd.start_calc = stray && (c == 3);
            cmd.start_load = stray && (c == 3);
            if (stray && c == 3) cmd.cfg_len = AW'(n);
            @(negedge clk);
            enb = (c >= 2) && (c <= n + 1);
            mac = (c >= 3) && (c <= n + 2);
            ab  = enb ? AW'(c - 2) : '0;
            chk($sformatf("calc_ctl n=%0d c=%0d", n, c), ctl_act,
                ctl_exp(1, 0, 0, c == n + 4, 0, enb, c == 1, mac, c == n + 3));
            chk($sformatf("calc_bus n=%0d c=%0d", n, c), bus_act,
                {AW'(0), AW'(0), ab, ab, W'(0), W'(0)});
            if (en_MAC) mac_cnt++;
            if (enb_r && int'(addrb_r) > max_b) max_b = int'(addrb_r);
            if (c == n + 4) chk($sformatf("calc_y n=%0d", n), y_q, exp_y);
            step();
        end
        cmd.start_calc = 1'b0;
        cmd.start_load = 1'b0;
        chk($sformatf("en_mac_cycles n=%0d", n), mac_cnt, n);
        chk($sformatf("addrb_max n=%0d", n), max_b, n - 1);
        @(negedge clk);
        chk("calc_after_idle", ctl_act, '0);
        step();
    endtask

    task automatic load_tbl(input int t);
        for (int i = 0; i < 15; i++) begin
            cur_row[i] = tbl[t].row[i];
            cur_col[i] = tbl[t].col[i];
        end
    endtask

    initial begin
        int dn;
        int n;
        for (int t = 0; t < 5; t++) begin
            tbl[t].n = 1; tbl[t].gap = 0; tbl[t].both = 0; tbl[t].stray = 0;
            tbl[t].row = '0; tbl[t].col = '0; tbl[t].exp_y = '0;
        end
        tbl[0].n = 6; tbl[0].exp_y = 32'd56;
        for (int i = 0; i < 6; i++) begin
            tbl[0].row[i] = W'(i + 1);
            tbl[0].col[i] = W'(6 - i);
        end
        tbl[1].n = 2; tbl[1].stray = 1; tbl[1].exp_y = 32'hFFFF_FFE6;
        tbl[1].row[0] = W'(-3); tbl[1].row[1] = W'(7);
        tbl[1].col[0] = W'(4);  tbl[1].col[1] = W'(-2);
        tbl[2].n = 4; tbl[2].gap = 1; tbl[2].exp_y = 32'hFFFF_FFFB;
        tbl[2].row[0] = W'(2); tbl[2].row[1] = W'(-1); tbl[2].row[2] = W'(3);  tbl[2].row[3] = W'(10);
        tbl[2].col[0] = W'(5); tbl[2].col[1] = W'(4);  tbl[2].col[2] = W'(-7); tbl[2].col[3] = W'(1);
        tbl[3].n = 3; tbl[3].both = 1; tbl[3].exp_y = 32'd1400;
        tbl[3].row[0] = W'(100); tbl[3].row[1] = W'(200); tbl[3].row[2] = W'(300);
        tbl[3].col[0] = W'(1);   tbl[3].col[1] = W'(2);   tbl[3].col[2] = W'(3);
        tbl[4].n = 15; tbl[4].exp_y = 32'd15;
        for (int i = 0; i < 15; i++) begin
            tbl[4].row[i] = W'(1);
            tbl[4].col[i] = W'(1);
        end

        rst = 1'b0;
        cmd.start_load = 1'b1; cmd.start_calc = 1'b1; cmd.cfg_len = AW'(5);
        cmd.ld_valid = 1'b1; cmd.ld_row = '1; cmd.ld_col = '1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_ctl", ctl_act, '0);
        chk("reset_bus", bus_act, '0);
        step();
        rst = 1'b1;
        cmd.start_load = 1'b0; cmd.start_calc = 1'b0; cmd.ld_valid = 1'b0;
        step();

        load_tbl(0);
        run_load(tbl[0].n, tbl[0].gap, tbl[0].both);
        run_calc(tbl[0].n, tbl[0].stray, tbl[0].exp_y);

        // Reset lands at the end of cycle 4 of an N=6 calc.
        cmd.start_calc = 1'b1;
        cmd.cfg_len    = AW'(6);
        step();
        cmd.start_calc = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("pre_reset_run", ctl_act, ctl_exp(1, 0, 0, 0, 0, 1, 0, 1, 0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_ctl", ctl_act, '0);
        chk("mid_reset_bus", bus_act, '0);
        dn = 0;
        repeat (10) begin
            step();
            @(negedge clk);
            if (cmd.done) dn++;
        end
        chk("no_done_after_reset", dn, 0);
        step();
        run_calc(6, 0, 32'd56);

        for (int t = 0; t < 3; t++) begin
            cmd.start_load = (t != 1);
            cmd.start_calc = (t != 0);
            cmd.cfg_len    = '0;
            step();
            cmd.start_load = 1'b0;
            cmd.start_calc = 1'b0;
            @(negedge clk);
            chk($sformatf("len0_ignored_%0d", t), ctl_act, '0);
            step();
        end

        for (int t = 1; t < 5; t++) begin
            load_tbl(t);
            run_load(tbl[t].n, tbl[t].gap, tbl[t].both);
            run_calc(tbl[t].n, tbl[t].stray, tbl[t].exp_y);
        end

        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 15);
            for (int i = 0; i < 15; i++) begin
                cur_row[i] = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 200)) - W'(100);
                cur_col[i] = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 200)) - W'(100);
            end
            run_load(n, 2, r[0]);
            run_calc(n, r[1], dot(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
